reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry x 32-bit integer register file for the single-cycle RV32I datapath.
- Sits directly upstream of the ALU:
  - RD1 drives ALU operand A.
  - RD2 drives the ALU B-side mux.
- Written back at the clock edge with the selected result (ALU Result, load data or PC+4).
- Two combinational read ports, one synchronous write port, one combinational debug read port.
- x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears every register.
- A1  input  5  read address, port 1 (rs1).
- A2  input  5  read address, port 2 (rs2).
- A3  input  5  write address (rd).
- WD3  input  XLEN  write data.
- WE3  input  1  write enable.
- RD1  output  XLEN  read data, port 1 (to ALU A).
- RD2  output  XLEN  read data, port 2 (to ALU B mux / store data).
- DA  input  5  debug read address.
- DRD  output  XLEN  debug read data.
- WR0  output  1  registered flag: previous edge carried a write attempt to x0.

Behaviour:
- Reset:
  - rst low asynchronously clears all NREGS entries to 0 and WR0 to 0.
  - While rst is low, writes are ignored and RD1/RD2/DRD read 0.
  - Release is synchronous to the next clk edge; the first write can land on the first rising edge with rst high.
- Write:
  - On a rising edge with rst high, WE3=1 and A3!=0: regs[A3] <= WD3.
  - The new value is visible on the read ports from that edge onward (latency 1 edge).
- x0:
  - Writes with A3=0 are discarded; regs[0] always reads 0.
  - WR0 <= WE3 & (A3==0) each edge. It is a one-cycle pulse per attempt, for verification and trace only.
- Read:
  - RD1 = regs[A1], RD2 = regs[A2], DRD = regs[DA]. All purely combinational, zero latency.
  - Address 0 always returns 0.
- Simultaneous events:
  - A1==A2: both ports return the same value.
  - Read address equal to A3 with WE3=1 in the same cycle returns the old (pre-edge) value, unless the optional bypass is compiled in.
  - WE3=1 with rst falling mid-cycle: reset wins and the write is lost.
- No stall or handshake: the single-cycle core writes at most once per cycle.
- WE3=0: contents are unchanged regardless of A3/WD3, including X on the WD3 bus.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-first bypass. For each read port (RD1, RD2, DRD), if WE3=1, A3!=0 and the read address equals A3, the port returns WD3 combinationally in the same cycle. Stored state is identical to the non-bypass build.
- Undefined: read-old-value behaviour as above. This is the default build for the single-cycle core.

Decomposition:
- Shared package gets:
  - XLEN and REG_ADDR_W (=5) constants;
  - REG_ZERO (=5'd0);
  - a reg_addr_t typedef, also reused by the decoder and ALU-side muxes.
- One sub-module is natural: reg_file_rdport, which takes the array, an address, the bypass inputs (A3/WE3/WD3) and the macro. It implements the zero check plus optional bypass for one port. Instantiate it three times (RD1, RD2, DRD).

Test Plan:
- Reset: hold rst=0 for 3 edges, then sweep DA 0..31 -> DRD=0 for every address, WR0=0.
- Basic write/read: WE3=1, A3=5, WD3=32'hDEADBEEF at edge; next cycle A1=5, A2=5 -> RD1=RD2=32'hDEADBEEF; other addresses still 0.
- x0 protection: WE3=1, A3=0, WD3=32'hFFFFFFFF -> after edge RD1(A1=0)=0 and WR0=1 for exactly one cycle; WR0=0 after an idle edge.
- Same-cycle read/write: regs[7]=32'h1, then WE3=1, A3=7, WD3=32'h2, A1=7 before edge:
  - Without REG_FILE_BYPASS_EN: RD1=32'h1.
  - With REG_FILE_BYPASS_EN: RD1=32'h2.
  - After the edge, both builds give 32'h2.
- Reset mid-operation: regs[10]=32'hA5A5A5A5, WE3=1, A3=10, WD3=32'h0F0F0F0F. Pull rst low between edges -> RD1(A1=10)=0 immediately; after release with WE3=0, still 0.
- Full sweep: write regs[i]=i*32'h01010101 for i=1..31 on consecutive edges, then read back pairs (A1=i, A2=31-i) -> exact values, RD for index 0 = 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the RV32I integer register file.
// Optional write-first bypass is selected by REG_FILE_BYPASS_EN (see reg_file_rdport).
package reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    // Register index type, shared with the decoder and the ALU-side muxes.
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [NREGS-1:0][XLEN-1:0] reg_array_t;

    localparam reg_addr_t REG_ZERO = '0;

    function automatic logic is_zero(input reg_addr_t addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register-file port bundle: two operand reads, one write, one debug read, x0-write flag.
// The datapath side uses the master modport; the register file uses the slave modport.
interface reg_file_if;
    import reg_file_pkg::*;

    // No handshake: a write is taken on every rising edge where WE3 is high, reads are
    // combinational and valid in the same cycle the address is presented.
    reg_addr_t A1;
    reg_addr_t A2;
    reg_addr_t A3;
    xlen_t     WD3;
    logic      WE3;
    xlen_t     RD1;
    xlen_t     RD2;
    reg_addr_t DA;
    xlen_t     DRD;
    logic      WR0;

    modport master (
        output A1, A2, A3, WD3, WE3, DA,
        input  RD1, RD2, DRD, WR0
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3, DA,
        output RD1, RD2, DRD, WR0
    );

endinterface

// File: rtl/reg_file_rdport.sv
// One combinational read port: x0 returns zero; with REG_FILE_BYPASS_EN defined a
// same-cycle write to the addressed register is forwarded (write-first).
module reg_file_rdport
    import reg_file_pkg::*;
(
    input  reg_array_t regs,
    input  reg_addr_t  addr,
    input  reg_addr_t  wr_addr,
    input  logic       wr_en,
    input  xlen_t      wr_data,
    output xlen_t      data
);

`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        data = '0;
        if (!is_zero(addr)) begin
            data = regs[addr];
            if (wr_en && (wr_addr == addr)) begin
                data = wr_data;
            end
        end
    end
`else
    // Bypass inputs are intentionally ignored in the read-old-value build.
    logic unused_bypass;
    assign unused_bypass = ^{wr_addr, wr_en, wr_data};

    always_comb begin
        data = '0;
        if (!is_zero(addr)) begin
            data = regs[addr];
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// 32 x 32 RV32I register file: x0 hardwired to zero, synchronous write, three
// combinational reads. Optional write-first bypass via REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);

    reg_array_t regs;
    logic       wr0;
    logic       byp_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
            wr0  <= 1'b0;
        end else begin
            wr0 <= bus.WE3 && is_zero(bus.A3);
            if (bus.WE3 && !is_zero(bus.A3)) begin
                regs[bus.A3] <= bus.WD3;
            end
        end
    end

    assign bus.WR0 = wr0;

    // A write that reset is about to discard must not be forwarded either.
    assign byp_we = bus.WE3 & rst;

    reg_file_rdport u_rd1 (
        .regs    (regs),
        .addr    (bus.A1),
        .wr_addr (bus.A3),
        .wr_en   (byp_we),
        .wr_data (bus.WD3),
        .data    (bus.RD1)
    );

    reg_file_rdport u_rd2 (
        .regs    (regs),
        .addr    (bus.A2),
        .wr_addr (bus.A3),
        .wr_en   (byp_we),
        .wr_data (bus.WD3),
        .data    (bus.RD2)
    );

    reg_file_rdport u_drd (
        .regs    (regs),
        .addr    (bus.DA),
        .wr_addr (bus.A3),
        .wr_en   (byp_we),
        .wr_data (bus.WD3),
        .data    (bus.DRD)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file; expectations for same-cycle reads follow REG_FILE_BYPASS_EN.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [XLEN-1:0] exp_q[$];

    reg_file_if bus ();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        bus.A1  = '0;
        bus.A2  = '0;
        bus.A3  = '0;
        bus.WD3 = '0;
        bus.WE3 = 1'b0;
        bus.DA  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        // A write attempted during reset must be ignored.
        bus.WE3 = 1'b1;
        bus.A3  = 5'd3;
        bus.WD3 = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NREGS; i++) begin
            bus.DA = reg_addr_t'(i);
            #1;
            n_cmp++;
            if (bus.DRD !== 32'h0) begin
                n_err++;
                $display("FAIL reset_drd[%0d]: got %h expected %h", i, bus.DRD, 32'h0);
            end
        end
        n_cmp++;
        if (bus.WR0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wr0: got %b expected 0", bus.WR0);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        bus.WE3 = 1'b1;
        bus.A3  = 5'd5;
        bus.WD3 = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.WE3 = 1'b0;
        bus.A1  = 5'd5;
        bus.A2  = 5'd5;
        bus.DA  = 5'd6;
        #1;
        n_cmp++;
        if (bus.RD1 !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL basic_rd1: got %h expected %h", bus.RD1, 32'hDEAD_BEEF);
        end
        n_cmp++;
        if (bus.RD2 !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL basic_rd2: got %h expected %h", bus.RD2, 32'hDEAD_BEEF);
        end
        n_cmp++;
        if (bus.DRD !== 32'h0) begin
            n_err++;
            $display("FAIL basic_other: got %h expected %h", bus.DRD, 32'h0);
        end
        bus.A1 = 5'd4;
        #1;
        n_cmp++;
        if (bus.RD1 !== 32'h0) begin
            n_err++;
            $display("FAIL basic_neighbour: got %h expected %h", bus.RD1, 32'h0);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        bus.WE3 = 1'b1;
        bus.A3  = 5'd0;
        bus.WD3 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.WE3 = 1'b0;
        bus.A1  = 5'd0;
        bus.DA  = 5'd0;
        #1;
        n_cmp++;
        if (bus.RD1 !== 32'h0) begin
            n_err++;
            $display("FAIL x0_rd1: got %h expected %h", bus.RD1, 32'h0);
        end
        n_cmp++;
        if (bus.DRD !== 32'h0) begin
            n_err++;
            $display("FAIL x0_drd: got %h expected %h", bus.DRD, 32'h0);
        end
        n_cmp++;
        if (bus.WR0 !== 1'b1) begin
            n_err++;
            $display("FAIL x0_wr0_pulse: got %b expected 1", bus.WR0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.WR0 !== 1'b0) begin
            n_err++;
            $display("FAIL x0_wr0_clear: got %b expected 0", bus.WR0);
        end
    endtask

    task automatic test_same_cycle();
        logic [XLEN-1:0] exp_early;
`ifdef REG_FILE_BYPASS_EN
        exp_early = 32'h2;
`else
        exp_early = 32'h1;
`endif
        @(negedge clk);
        bus.WE3 = 1'b1;
        bus.A3  = 5'd7;
        bus.WD3 = 32'h1;
        @(posedge clk);
        #1;
        bus.WD3 = 32'h2;
        bus.A1  = 5'd7;
        bus.A2  = 5'd7;
        bus.DA  = 5'd7;
        #1;
        n_cmp++;
        if (bus.RD1 !== exp_early) begin
            n_err++;
            $display("FAIL same_cycle_rd1: got %h expected %h", bus.RD1, exp_early);
        end
        n_cmp++;
        if (bus.RD2 !== exp_early) begin
            n_err++;
            $display("FAIL same_cycle_rd2: got %h expected %h", bus.RD2, exp_early);
        end
        n_cmp++;
        if (bus.DRD !== exp_early) begin
            n_err++;
            $display("FAIL same_cycle_drd: got %h expected %h", bus.DRD, exp_early);
        end
        @(posedge clk);
        #1;
        bus.WE3 = 1'b0;
        #1;
        n_cmp++;
        if (bus.RD1 !== 32'h2) begin
            n_err++;
            $display("FAIL same_cycle_after: got %h expected %h", bus.RD1, 32'h2);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.WE3 = 1'b1;
        bus.A3  = 5'd10;
        bus.WD3 = 32'hA5A5_A5A5;
        bus.A1  = 5'd10;
        @(posedge clk);
        #1;
        bus.WD3 = 32'h0F0F_0F0F;
        #1;
        n_cmp++;
        if (bus.RD1 === 32'h0 || bus.RD1 === 32'hxxxx_xxxx) begin
            n_err++;
            $display("FAIL reset_mid_pre: got %h expected nonzero", bus.RD1);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.RD1 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_async: got %h expected %h", bus.RD1, 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        bus.WE3 = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.RD1 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_release: got %h expected %h", bus.RD1, 32'h0);
        end
    endtask

    task automatic test_full_sweep();
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] exp;
        for (int i = 1; i < NREGS; i++) begin
            @(negedge clk);
            wd      = XLEN'(i);
            bus.WE3 = 1'b1;
            bus.A3  = reg_addr_t'(i);
            bus.WD3 = wd * 32'h0101_0101;
        end
        @(negedge clk);
        bus.WE3 = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            wd = XLEN'(i);
            exp_q.push_back(wd * 32'h0101_0101);
            wd = XLEN'(NREGS - 1 - i);
            exp_q.push_back(wd * 32'h0101_0101);
            bus.A1 = reg_addr_t'(i);
            bus.A2 = reg_addr_t'(NREGS - 1 - i);
            #1;
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.RD1 !== exp) begin
                n_err++;
                $display("FAIL sweep_rd1[%0d]: got %h expected %h", i, bus.RD1, exp);
            end
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.RD2 !== exp) begin
                n_err++;
                $display("FAIL sweep_rd2[%0d]: got %h expected %h", NREGS - 1 - i, bus.RD2, exp);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        bus.WE3 = 1'b0;
        bus.A3  = 5'd5;
        bus.WD3 = 'x;
        bus.DA  = 5'd5;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.DRD !== 32'h0505_0505) begin
            n_err++;
            $display("FAIL hold_we0: got %h expected %h", bus.DRD, 32'h0505_0505);
        end
        bus.WD3 = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic_write();
        test_x0();
        test_same_cycle();
        test_reset_mid();
        test_full_sweep();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
